// File: rtl/pack_8_to_904.sv
`default_nettype none
// ============================================================================
// Module      : pack_8_to_904
// Description : Ping-pong byte-to-word packer, 113 x 8-bit bytes -> 904 bits.
// Revision    : 1.0  initial release
// ============================================================================
module pack_8_to_904 #(
    parameter  int BYTE_W    = 8,
    parameter  int NUM_BYTES = 113,
    localparam int OUT_W     = BYTE_W * NUM_BYTES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              din_vld,
    input  logic [BYTE_W-1:0] din,
    output logic              din_rdy,
    output logic [OUT_W-1:0]  dout,
    output logic              dout_vld,
    input  logic              dout_rdy,
    output logic              ovf_err
);

    localparam int                C_CNT_W = $clog2(NUM_BYTES);
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(NUM_BYTES - 1);

    logic [OUT_W-1:0]   r_buf [2];
    logic               r_wr_sel;
    logic               r_rd_sel;
    logic [C_CNT_W-1:0] r_wr_cnt;
    logic [1:0]         r_full;
    logic               r_ovf;

    logic               w_accept;
    logic               w_drain;
    logic               w_last;
    logic [1:0]         w_full_nxt;

    assign din_rdy  = !r_full[r_wr_sel];
    assign dout_vld = r_full[r_rd_sel];
    // Gated so nothing uninitialised reaches the datapath before the first word.
    assign dout     = dout_vld ? r_buf[r_rd_sel] : '0;
    assign ovf_err  = r_ovf;

    assign w_accept = din_vld && din_rdy && !clr;
    assign w_drain  = dout_vld && dout_rdy;
    assign w_last   = (r_wr_cnt == C_LAST);

    // Filling and draining buffers always differ, so both updates can apply.
    always_comb begin
        w_full_nxt = r_full;
        if (w_drain) begin
            w_full_nxt[r_rd_sel] = 1'b0;
        end
        if (w_accept && w_last) begin
            w_full_nxt[r_wr_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_wr_cnt <= '0;
            r_full   <= 2'b00;
            r_ovf    <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_drain) begin
                r_rd_sel <= ~r_rd_sel;
            end
            if (clr) begin
                r_wr_cnt <= '0;
                r_ovf    <= 1'b0;
            end else begin
                if (din_vld && !din_rdy) begin
                    r_ovf <= 1'b1;
                end
                if (w_accept) begin
                    if (w_last) begin
                        r_wr_cnt <= '0;
                        r_wr_sel <= ~r_wr_sel;
                    end else begin
                        r_wr_cnt <= r_wr_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Buffer storage carries no reset; validity is tracked by r_full alone.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_wr_sel][r_wr_cnt*BYTE_W +: BYTE_W] <= din;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pack_8_to_904.sv
`default_nettype none
// ============================================================================
// Module      : tb_pack_8_to_904
// Description : Directed bench for pack_8_to_904 with a word-queue model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pack_8_to_904;

    localparam int C_NB  = 113;
    localparam int C_W   = 904;

    logic           clk;
    logic           rst_n;
    logic           clr;
    logic           din_vld;
    logic [7:0]     din;
    logic           din_rdy;
    logic [C_W-1:0] dout;
    logic           dout_vld;
    logic           dout_rdy;
    logic           ovf_err;

    int             nvec;
    int             nerr;
    int             vld_cycles;
    int             rdy_low;
    logic [C_W-1:0] dut_words [$];

    // Model: queue of completed words plus the word being assembled.
    logic [C_W-1:0] mq [$];
    logic [C_W-1:0] part;
    int             cnt;
    bit             movf;

    pack_8_to_904 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .din_vld  (din_vld),
        .din      (din),
        .din_rdy  (din_rdy),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .ovf_err  (ovf_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] word_byte(input int w, input int k);
        if (w >= dut_words.size()) return 8'hxx;
        return dut_words[w][k*8 +: 8];
    endfunction

    always @(negedge clk) begin
        logic acc;
        logic drn;
        if (!rst_n) begin
            mq.delete();
            cnt  = 0;
            movf = 1'b0;
            part = '0;
        end
        chk("dout_vld", {31'b0, dout_vld}, {31'b0, mq.size() > 0});
        chk("din_rdy",  {31'b0, din_rdy},  {31'b0, mq.size() < 2});
        chk("ovf_err",  {31'b0, ovf_err},  {31'b0, movf});
        if (mq.size() > 0) begin
            nvec++;
            if (dout !== mq[0]) begin
                nerr++;
                for (int k = 0; k < C_NB; k++) begin
                    if (dout[k*8 +: 8] !== mq[0][k*8 +: 8]) begin
                        $display("FAIL dout byte %0d: got %0h expected %0h at %0t",
                                 k, dout[k*8 +: 8], mq[0][k*8 +: 8], $time);
                        break;
                    end
                end
            end
        end
        if (rst_n) begin
            if (dout_vld && dout_rdy) dut_words.push_back(dout);
            if (dout_vld) vld_cycles++;
            if (!din_rdy) rdy_low++;
            acc = din_vld && (mq.size() < 2) && !clr;
            drn = (mq.size() > 0) && dout_rdy;
            if (clr) begin
                cnt  = 0;
                movf = 1'b0;
            end else if (din_vld && mq.size() >= 2) begin
                movf = 1'b1;
            end
            if (drn) void'(mq.pop_front());
            if (acc) begin
                part[cnt*8 +: 8] = din;
                cnt++;
                if (cnt == C_NB) begin
                    mq.push_back(part);
                    cnt = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        din_vld = 1'b1;
        din     = b;
        step();
        din_vld = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        dut_words.delete();
        vld_cycles = 0;
        rdy_low    = 0;
    endtask

    initial begin
        logic [7:0] b0;
        nvec = 0; nerr = 0; vld_cycles = 0; rdy_low = 0;
        rst_n = 1'b0; clr = 1'b0; din_vld = 1'b0; din = '0; dout_rdy = 1'b0;
        step();
        chk("reset dout_vld", {31'b0, dout_vld}, 32'd0);
        chk("reset din_rdy",  {31'b0, din_rdy},  32'd1);
        chk("reset ovf_err",  {31'b0, ovf_err},  32'd0);
        do_reset();

        // Single word fill
        dout_rdy = 1'b1;
        for (int k = 0; k < C_NB; k++) push(8'(k));
        repeat (3) step();
        chk("t1 words",      dut_words.size(), 32'd1);
        chk("t1 vld cycles", vld_cycles, 32'd1);
        chk("t1 rdy low",    rdy_low, 32'd0);
        chk("t1 byte0",      {24'b0, word_byte(0, 0)},   32'h00);
        chk("t1 byte1",      {24'b0, word_byte(0, 1)},   32'h01);
        chk("t1 byte112",    {24'b0, word_byte(0, 112)}, 32'h70);

        // Back-pressure
        do_reset();
        dout_rdy = 1'b0;
        for (int k = 0; k < 227; k++) push(8'(k));
        chk("t2 din_rdy low", {31'b0, din_rdy}, 32'd0);
        chk("t2 ovf_err",     {31'b0, ovf_err}, 32'd1);
        dout_rdy = 1'b1;
        step();
        chk("t2 rdy after drain", {31'b0, din_rdy}, 32'd1);
        repeat (3) step();
        chk("t2 words",    dut_words.size(), 32'd2);
        chk("t2 A byte0",  {24'b0, word_byte(0, 0)},   32'h00);
        chk("t2 A byte112",{24'b0, word_byte(0, 112)}, 32'h70);
        chk("t2 B byte0",  {24'b0, word_byte(1, 0)},   32'h71);
        chk("t2 B byte112",{24'b0, word_byte(1, 112)}, 32'hE1);

        // Streaming
        do_reset();
        dout_rdy = 1'b1;
        for (int k = 0; k < 1130; k++) push(8'(k));
        repeat (3) step();
        chk("t3 handshakes", dut_words.size(), 32'd10);
        chk("t3 rdy low",    rdy_low, 32'd0);
        chk("t3 w9 byte0",   {24'b0, word_byte(9, 0)},   32'hF9);
        chk("t3 w9 byte112", {24'b0, word_byte(9, 112)}, 32'h69);

        // clr mid-word; the byte in the clr cycle is ignored
        do_reset();
        dout_rdy = 1'b1;
        for (int k = 0; k < 50; k++) push(8'(8'h55 + k));
        clr = 1'b1; din_vld = 1'b1; din = 8'hEE;
        step();
        clr = 1'b0; din_vld = 1'b0;
        chk("t4 ovf after clr", {31'b0, ovf_err}, 32'd0);
        for (int k = 0; k < C_NB; k++) push(8'(8'hA0 + k));
        repeat (3) step();
        chk("t4 words",      dut_words.size(), 32'd1);
        chk("t4 byte0",      {24'b0, word_byte(0, 0)},   32'hA0);
        chk("t4 byte112",    {24'b0, word_byte(0, 112)}, 32'h10);

        // Completion and drain in the same cycle
        do_reset();
        dout_rdy = 1'b0;
        for (int k = 0; k < C_NB; k++) push(8'(k));
        for (int k = 0; k < C_NB - 1; k++) push(8'(8'h80 + k));
        din_vld = 1'b1; din = 8'hF0; dout_rdy = 1'b1;
        step();
        din_vld = 1'b0;
        b0 = dout[7:0];
        chk("t5 dout_vld", {31'b0, dout_vld}, 32'd1);
        chk("t5 din_rdy",  {31'b0, din_rdy},  32'd1);
        chk("t5 byte0",    {24'b0, b0}, 32'h80);
        repeat (3) step();
        chk("t5 words",    dut_words.size(), 32'd2);
        chk("t5 X byte0",  {24'b0, word_byte(0, 0)},   32'h00);
        chk("t5 Y byte112",{24'b0, word_byte(1, 112)}, 32'hF0);

        // Async reset mid-word with a word pending
        do_reset();
        dout_rdy = 1'b0;
        for (int k = 0; k < C_NB + 60; k++) push(8'(k));
        rst_n = 1'b0;
        #1;
        chk("t6 dout_vld", {31'b0, dout_vld}, 32'd0);
        chk("t6 din_rdy",  {31'b0, din_rdy},  32'd1);
        chk("t6 ovf_err",  {31'b0, ovf_err},  32'd0);
        do_reset();
        dout_rdy = 1'b1;
        for (int k = 0; k < C_NB; k++) push(8'(8'h30 + k));
        repeat (3) step();
        chk("t6 words",    dut_words.size(), 32'd1);
        chk("t6 byte0",    {24'b0, word_byte(0, 0)},   32'h30);
        chk("t6 byte112",  {24'b0, word_byte(0, 112)}, 32'hA0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
